// File: rtl/pixel_downloader.sv
// Write-direction pixel DMA: gathers 6 or 8 FIFO words per beat and stores each 256-bit beat
// to a circular frame region through an Avalon-MM master write port.
module pixel_downloader (
  input  logic         clk,
  input  logic         rst_n,
  output logic [32:0]  avl_mm_addr,
  output logic         avl_mm_write,
  output logic [255:0] avl_mm_writedata,
  output logic [31:0]  avl_mm_byteenable,
  input  logic         avl_mm_waitrequest,
  input  logic         avl_mm_writeresponsevalid,
  input  logic [1:0]   avl_mm_response,
  output logic         pix_fifo_read,
  input  logic [31:0]  pix_fifo_data,
  input  logic         pix_fifo_empty,
  input  logic [9:0]   pix_fifo_usedw,
  input  logic         enable,
  input  logic         word_mode,
  input  logic [31:0]  base_address,
  input  logic [31:0]  total_size,
  input  logic         transform_data,
  output logic         write_error,
  output logic         frame_done,
  output logic         active
);

  typedef enum logic [1:0] {StIdle, StGather, StWrite} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] slot_q [8];
  logic [31:0] slot_d [8];
  logic        tr_q, tr_d;
  logic        wm_q, wm_d;
  logic        enable_q;
  logic [31:0] base_q, base_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        write_q, write_d;
  logic        read_q, read_d;
  logic        active_q, active_d;

  logic [3:0]   need;
  logic [3:0]   beat_len;
  logic         can_start;
  logic         accept;
  logic [31:0]  addr_next;
  logic         wrap;
  logic [191:0] packed_v;
  logic [255:0] wdata;

  always_comb begin
    need      = transform_data ? 4'd6 : 4'd8;
    beat_len  = tr_q ? 4'd6 : 4'd8;
    can_start = enable && !err_q && !pix_fifo_empty && (pix_fifo_usedw >= {6'd0, need});
    accept    = write_q && !avl_mm_waitrequest;
    addr_next = addr_q + (wm_q ? 32'd1 : 32'd32);
    wrap      = (addr_next == base_q + total_size);

    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    tr_d    = tr_q;
    wm_d    = wm_q;
    base_d  = base_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    write_d = write_q;
    read_d  = read_q;

    // Set wins over clear so an error arriving while disabled is not lost.
    err_d = err_q;
    if (avl_mm_writeresponsevalid && (avl_mm_response != 2'b00)) begin
      err_d = 1'b1;
    end else if (!enable) begin
      err_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (can_start) begin
          state_d = StGather;
          cnt_d   = 4'd0;
          tr_d    = transform_data;
          wm_d    = word_mode;
          read_d  = 1'b1;
        end
      end
      StGather: begin
        // Data for the strobe issued at count k arrives while the count is k+1.
        if (cnt_q != 4'd0) begin
          slot_d[3'(cnt_q - 4'd1)] = pix_fifo_data;
        end
        cnt_d  = cnt_q + 4'd1;
        read_d = ((cnt_q + 4'd1) < beat_len);
        if (cnt_q == beat_len) begin
          state_d = StWrite;
          write_d = 1'b1;
          read_d  = 1'b0;
        end
      end
      StWrite: begin
        if (accept) begin
          write_d = 1'b0;
          addr_d  = wrap ? base_q : addr_next;
          done_d  = wrap;
          if (can_start) begin
            state_d = StGather;
            cnt_d   = 4'd0;
            tr_d    = transform_data;
            wm_d    = word_mode;
            read_d  = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (enable && !enable_q) begin
      base_d = base_address;
      addr_d = base_address;
    end

    active_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      slot_q   <= '{default: '0};
      tr_q     <= 1'b0;
      wm_q     <= 1'b0;
      enable_q <= 1'b0;
      base_q   <= 32'd0;
      addr_q   <= 32'd0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      write_q  <= 1'b0;
      read_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      slot_q   <= slot_d;
      tr_q     <= tr_d;
      wm_q     <= wm_d;
      enable_q <= enable;
      base_q   <= base_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
      done_q   <= done_d;
      write_q  <= write_d;
      read_q   <= read_d;
      active_q <= active_d;
    end
  end

  // Packed mode: pixel p is V[24p+:24], zero-extended into a 32-bit lane.
  always_comb begin
    packed_v = {slot_q[5], slot_q[4], slot_q[3], slot_q[2], slot_q[1], slot_q[0]};
    wdata    = '0;
    for (int k = 0; k < 8; k++) begin
      if (tr_q) begin
        wdata[32*k +: 32] = {8'h00, packed_v[24*k +: 24]};
      end else begin
        wdata[32*k +: 32] = slot_q[k];
      end
    end
  end

  assign avl_mm_addr       = {1'b0, addr_q};
  assign avl_mm_write      = write_q;
  assign avl_mm_writedata  = wdata;
  assign avl_mm_byteenable = {32{write_q}};
  assign pix_fifo_read     = read_q;
  assign write_error       = err_q;
  assign frame_done        = done_q;
  assign active            = active_q;

  read_never_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(pix_fifo_read && pix_fifo_empty));

endmodule

// File: tb/tb_pixel_downloader.sv
// Scoreboard bench for pixel_downloader: a FIFO model feeds the DUT, expected beats come from
// a byte-level reference model, and a negedge monitor checks every accepted write.
module tb_pixel_downloader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [32:0]  avl_mm_addr;
  logic         avl_mm_write;
  logic [255:0] avl_mm_writedata;
  logic [31:0]  avl_mm_byteenable;
  logic         avl_mm_waitrequest;
  logic         avl_mm_writeresponsevalid;
  logic [1:0]   avl_mm_response;
  logic         pix_fifo_read;
  logic [31:0]  pix_fifo_data;
  logic         pix_fifo_empty;
  logic [9:0]   pix_fifo_usedw;
  logic         enable;
  logic         word_mode;
  logic [31:0]  base_address;
  logic [31:0]  total_size;
  logic         transform_data;
  logic         write_error;
  logic         frame_done;
  logic         active;

  pixel_downloader dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .avl_mm_addr               (avl_mm_addr),
    .avl_mm_write              (avl_mm_write),
    .avl_mm_writedata          (avl_mm_writedata),
    .avl_mm_byteenable         (avl_mm_byteenable),
    .avl_mm_waitrequest        (avl_mm_waitrequest),
    .avl_mm_writeresponsevalid (avl_mm_writeresponsevalid),
    .avl_mm_response           (avl_mm_response),
    .pix_fifo_read             (pix_fifo_read),
    .pix_fifo_data             (pix_fifo_data),
    .pix_fifo_empty            (pix_fifo_empty),
    .pix_fifo_usedw            (pix_fifo_usedw),
    .enable                    (enable),
    .word_mode                 (word_mode),
    .base_address              (base_address),
    .total_size                (total_size),
    .transform_data            (transform_data),
    .write_error               (write_error),
    .frame_done                (frame_done),
    .active                    (active)
  );

  initial forever #5 clk = ~clk;

  // Non-show-ahead FIFO model: the stimulus owns wr_ptr, the read port owns rd_ptr.
  logic [31:0] fifo_mem [1024];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  assign pix_fifo_usedw = 10'(wr_ptr - rd_ptr);
  assign pix_fifo_empty = (wr_ptr == rd_ptr);

  always_ff @(posedge clk) begin
    if (pix_fifo_read) begin
      pix_fifo_data <= fifo_mem[rd_ptr % 1024];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  typedef struct {
    logic [32:0]  addr;
    logic [255:0] data;
    logic         wrap;
  } beat_t;

  beat_t       exp_q [$];
  logic [31:0] beat_w [8];
  logic [31:0] m_base, m_addr, m_total;
  bit          m_wm;
  int          vectors = 0;
  int          errors = 0;
  bit          fd_pending = 0;
  bit          fd_exp = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_beat();
    for (int k = 0; k < 8; k++) beat_w[k] = $urandom;
  endtask

  task automatic push_words(input int lo, input int hi);
    for (int k = lo; k < hi; k++) begin
      fifo_mem[wr_ptr % 1024] = beat_w[k];
      wr_ptr++;
    end
  endtask

  // Reference: the beat is a byte stream; packed mode inserts a zero after every 3 bytes.
  task automatic expect_beat(input bit tr);
    beat_t       b;
    logic [31:0] nxt;
    int          idx;
    b.addr = {1'b0, m_addr};
    b.data = '0;
    idx    = 0;
    for (int i = 0; i < 32; i++) begin
      if (!tr) begin
        b.data[8*i +: 8] = beat_w[i/4][8*(i%4) +: 8];
      end else if (i % 4 != 3) begin
        b.data[8*i +: 8] = beat_w[idx/4][8*(idx%4) +: 8];
        idx++;
      end
    end
    nxt    = m_addr + (m_wm ? 32'd1 : 32'd32);
    b.wrap = (nxt == m_base + m_total);
    m_addr = b.wrap ? m_base : nxt;
    exp_q.push_back(b);
  endtask

  task automatic set_region(input logic [31:0] base, input logic [31:0] total, input bit wm);
    base_address = base;
    total_size   = total;
    word_mode    = wm;
    m_base       = base;
    m_addr       = base;
    m_total      = total;
    m_wm         = wm;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || active || fd_pending) && n < budget) begin
      tick(1);
      n++;
    end
    check("drain_done", 256'(n < budget), 256'd1);
  endtask

  task automatic wait_write(input int budget);
    int n = 0;
    while (!avl_mm_write && n < budget) begin
      tick(1);
      n++;
    end
    check("write_seen", avl_mm_write, 1);
  endtask

  // Monitor: acceptance is decided by values stable at the negedge before the active edge.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (fd_pending) begin
        check("frame_done", frame_done, fd_exp);
        fd_pending = 0;
      end
      if (rst_n && avl_mm_write && !avl_mm_waitrequest) begin
        check("write_expected", 256'(exp_q.size() != 0), 256'd1);
        if (exp_q.size() != 0) begin
          b = exp_q.pop_front();
          check("beat_addr", avl_mm_addr, b.addr);
          check("beat_data", avl_mm_writedata, b.data);
          check("beat_byteenable", avl_mm_byteenable, 32'hffff_ffff);
          fd_exp     = b.wrap;
          fd_pending = 1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          r0;
    logic [32:0] a0;
    logic [255:0] d0;

    rst_n = 1'b0;
    enable = 1'b0;
    word_mode = 1'b0;
    base_address = '0;
    total_size = '0;
    transform_data = 1'b0;
    avl_mm_waitrequest = 1'b0;
    avl_mm_writeresponsevalid = 1'b0;
    avl_mm_response = 2'b00;
    tick(2);
    check("rst_addr", avl_mm_addr, 0);
    check("rst_write", avl_mm_write, 0);
    check("rst_byteenable", avl_mm_byteenable, 0);
    check("rst_writedata", avl_mm_writedata, 0);
    check("rst_fifo_read", pix_fifo_read, 0);
    check("rst_write_error", write_error, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_active", active, 0);
    rst_n = 1'b1;
    tick(2);

    // Direct mode over a two-beat frame, with the start-up latency measured.
    set_region(32'h1000, 32'h40, 1'b0);
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 8; k++) beat_w[k] = 32'(8*b + k);
      expect_beat(1'b0);
      push_words(0, 8);
    end
    enable = 1'b1;
    tick(1);
    check("first_read", pix_fifo_read, 1);
    check("active_rise", active, 1);
    lat = 1;
    while (!avl_mm_write && lat < 40) begin
      tick(1);
      lat++;
    end
    check("write_latency", lat, 10);
    drain(200);
    check("addr_after_wrap", avl_mm_addr, 33'h1000);

    for (int b = 0; b < 6; b++) begin
      rand_beat();
      expect_beat(1'b0);
      push_words(0, 8);
    end
    drain(400);

    // Packed-pixel mode: fixed byte ramp first, then random beats.
    transform_data = 1'b1;
    for (int k = 0; k < 6; k++) beat_w[k] = 32'h0302_0100 + 32'(k) * 32'h0404_0404;
    r0 = rd_ptr;
    expect_beat(1'b1);
    push_words(0, 6);
    drain(100);
    check("transform_reads", rd_ptr - r0, 6);
    for (int b = 0; b < 4; b++) begin
      rand_beat();
      expect_beat(1'b1);
      push_words(0, 6);
    end
    drain(300);

    // Stall: a second beat is queued in the FIFO but must not be gathered yet.
    transform_data = 1'b0;
    avl_mm_waitrequest = 1'b1;
    for (int b = 0; b < 2; b++) begin
      rand_beat();
      expect_beat(1'b0);
      push_words(0, 8);
    end
    wait_write(40);
    a0 = avl_mm_addr;
    d0 = avl_mm_writedata;
    r0 = rd_ptr;
    tick(5);
    check("stall_addr", avl_mm_addr, a0);
    check("stall_data", avl_mm_writedata, d0);
    check("stall_write", avl_mm_write, 1);
    check("stall_no_reads", rd_ptr, r0);
    avl_mm_waitrequest = 1'b0;
    drain(200);
    check("stall_addr_adv", avl_mm_addr, {1'b0, m_addr});

    // Threshold and word-granular addressing.
    enable = 1'b0;
    tick(1);
    set_region(32'h10, 32'h100, 1'b1);
    enable = 1'b1;
    tick(1);
    rand_beat();
    r0 = rd_ptr;
    push_words(0, 7);
    tick(12);
    check("threshold_no_reads", rd_ptr, r0);
    check("threshold_idle", active, 0);
    expect_beat(1'b0);
    push_words(7, 8);
    for (int b = 0; b < 2; b++) begin
      rand_beat();
      expect_beat(1'b0);
      push_words(0, 8);
    end
    drain(200);
    check("word_mode_addr", avl_mm_addr, 33'h13);

    // Error response blocks further beats until enable is cycled.
    enable = 1'b0;
    tick(1);
    set_region(32'h2000, 32'h1000, 1'b0);
    enable = 1'b1;
    rand_beat();
    expect_beat(1'b0);
    push_words(0, 8);
    drain(100);
    avl_mm_writeresponsevalid = 1'b1;
    avl_mm_response = 2'b10;
    tick(1);
    avl_mm_writeresponsevalid = 1'b0;
    avl_mm_response = 2'b00;
    check("error_set", write_error, 1);
    rand_beat();
    r0 = rd_ptr;
    push_words(0, 8);
    tick(20);
    check("error_no_reads", rd_ptr, r0);
    check("error_idle", active, 0);
    check("error_sticky", write_error, 1);
    enable = 1'b0;
    tick(1);
    check("error_cleared", write_error, 0);
    set_region(32'h3000, 32'h1000, 1'b0);
    expect_beat(1'b0);
    enable = 1'b1;
    drain(100);
    check("restart_addr", avl_mm_addr, 33'h3020);

    // Abort: enable dropped while gathering still completes that one beat.
    rand_beat();
    r0 = rd_ptr;
    expect_beat(1'b0);
    push_words(0, 8);
    lat = 0;
    while (!pix_fifo_read && lat < 20) begin
      tick(1);
      lat++;
    end
    check("abort_read_seen", pix_fifo_read, 1);
    tick(2);
    enable = 1'b0;
    drain(100);
    check("abort_reads", rd_ptr - r0, 8);
    check("abort_idle", active, 0);

    // Reset during a stalled write must drop the request immediately.
    avl_mm_waitrequest = 1'b1;
    rand_beat();
    push_words(0, 8);
    enable = 1'b1;
    wait_write(40);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_write_drop", avl_mm_write, 0);
    check("reset_active", active, 0);
    check("reset_addr", avl_mm_addr, 0);
    check("reset_read", pix_fifo_read, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pixel_downloader.md
# pixel_downloader

Write-direction DMA that drains 32-bit pixel words from a pixel FIFO and stores them in memory through a 256-bit Avalon-MM master write interface. Each memory beat holds either 8 direct FIFO words, or 6 FIFO words of packed 3-byte pixels expanded to 8 pixels of 4 bytes, with byte 3 of each pixel written as zero. It fills a circular frame region in memory, for example a capture path or a read-back of the pixel stream.

## Interface
- No parameters.
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- avl_mm_addr  out  33  {1'b0, current_address}
- avl_mm_write  out  1  write request; held until accepted
- avl_mm_writedata  out  256  beat data
- avl_mm_byteenable  out  32  all ones while avl_mm_write is high, 0 otherwise
- avl_mm_waitrequest  in  1  slave stall
- avl_mm_writeresponsevalid  in  1  write response strobe
- avl_mm_response  in  2  non-zero means error
- pix_fifo_read  out  1  read strobe; FIFO is non-show-ahead, so data is valid the cycle after the strobe
- pix_fifo_data  in  32  pixel word
- pix_fifo_empty  in  1  FIFO empty
- pix_fifo_usedw  in  10  FIFO fill level
- enable  in  1  run; a rising edge loads base_address
- word_mode  in  1  1: address advances 1 per beat; 0: address advances 32 per beat
- base_address  in  32  frame start
- total_size  in  32  frame size, in address units
- transform_data  in  1  1: FIFO carries packed 3-byte pixels (6 words per beat); 0: 8 words per beat
- write_error  out  1  sticky error flag
- frame_done  out  1  one-cycle pulse when the address wraps to base
- active  out  1  high whenever the state is not IDLE
- Reset values: every output is 0; avl_mm_addr = 0.

## Operation
- N = 6 if transform_data else 8. transform_data and word_mode are latched on entry to GATHER and held for that beat.
- Rising edge of enable, detected against a registered copy of enable:
  - base_reg <= base_address
  - current_address <= base_address
- FSM states and transitions:
  - IDLE -> GATHER when enable && !write_error && pix_fifo_usedw >= N.
  - GATHER: pix_fifo_read is high for exactly N consecutive cycles. Word k is captured into slot k one cycle after its read strobe.
  - GATHER -> WRITE on the cycle after the last capture.
  - WRITE: avl_mm_write = 1, with addr and writedata stable until the first cycle where avl_mm_write && !avl_mm_waitrequest.
  - On acceptance, advance current_address by (word_mode ? 1 : 32).
  - After acceptance, go to GATHER if the IDLE entry condition holds, else IDLE.
- Data mapping when transform_data = 0: slot k goes to writedata[32k+:32].
- Data mapping when transform_data = 1:
  - The 6 slots form a 192-bit vector V, with slot k at V[32k+:32].
  - Writedata byte i with i%4 == 3 is 0.
  - Every other writedata byte takes the next byte of V in ascending order; pixel p is bytes V[24p+:24].
- Wrap: if the advanced address equals base_reg + total_size (32-bit modulo), load base_reg instead and pulse frame_done in the cycle after acceptance.
- Error: avl_mm_writeresponsevalid && avl_mm_response != 0 sets write_error in any state.
  - The flag clears only while enable = 0.
  - A beat already in WRITE still completes its handshake; then the FSM goes to IDLE.
- enable deasserted mid-operation:
  - In GATHER, remaining reads still issue, so the FIFO stays word-aligned.
  - The beat is written, then the FSM goes to IDLE.
  - No Avalon write is ever withdrawn.
- Reset mid-operation: return immediately to IDLE with all outputs 0; a partial beat is discarded.
- pix_fifo_read must never be asserted while pix_fifo_empty = 1. This is guaranteed by the usedw check; treat a violation as an assertion failure.

## Timing
- Condition true in IDLE at cycle c: first pix_fifo_read at c+1, last read at c+N.
- avl_mm_write first rises at c+N+2.
- Zero-wait throughput: one beat per N+2 cycles. The acceptance cycle is followed directly by GATHER when data is available.
- frame_done and the address update are visible in the cycle after acceptance.
- write_error is registered; it is high in the cycle after the error response.
- active tracks the state register, so it is 1 from c+1.

## Test plan
- Direct mode, wrap: transform=0, word_mode=0, base=0x1000, total=0x40, FIFO words 0..15.
  - Expect beats at 0x1000 then 0x1020, each with writedata[32k+:32] = word k.
  - frame_done pulses after the second beat, and the next address is 0x1000.
- Transform mode: transform=1, FIFO words 0x03020100, 0x07060504, ..., 0x17161514.
  - Expect writedata[31:0] = 0x00020100, [63:32] = 0x00050403, and [255:224] = 0x00171615.
  - Exactly 6 reads are issued.
- Waitrequest: hold avl_mm_waitrequest for 5 cycles.
  - Addr, data and write stay stable and no FIFO reads occur; the address advances once after release.
- Error path: a response of 2'b10 on the first beat sets write_error.
  - No further writes occur while enable = 1.
  - Toggling enable 0 then 1 clears the error, reloads base, and restarts.
- Threshold and word mode: transform=0 with usedw=7 gives no reads; usedw=8 starts a beat.
  - word_mode=1 from base 0x10 gives addresses 0x10, 0x11, 0x12.
- Abort: deassert enable during GATHER.
  - All N reads complete, one beat is written, the FSM goes to IDLE and active drops.
  - Asserting rst_n low mid-WRITE drops avl_mm_write the same cycle.
